// File: rtl/rally_sequencer.sv
// Match round controller: IDLE/READY/SERVE/PLAY/POINT/CHECK/END with tick-based dwell timing and scoring.
// Scores/state are registered; point_pulse and freeze decode the current cycle. pause holds timing in active states.
module rally_sequencer #(
    parameter int TICK_DIV    = 1000000,
    parameter int READY_TICKS = 100,
    parameter int SERVE_TICKS = 50,
    parameter int POINT_TICKS = 50,
    parameter int WIN_SCORE   = 7,
    parameter int NET_X       = 160
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run_en,
    input  logic        pause,
    input  logic        floor_hit,
    input  logic [11:0] ball_x,
    output logic [1:0]  game_state,
    output logic        who_win,
    output logic        winner,
    output logic [3:0]  player_score,
    output logic [3:0]  computer_score,
    output logic        point_pulse,
    output logic        freeze
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [15:0]   READY_LAST = 16'(READY_TICKS - 1);
    localparam logic [15:0]   SERVE_LAST = 16'(SERVE_TICKS - 1);
    localparam logic [15:0]   POINT_LAST = 16'(POINT_TICKS - 1);
    localparam logic [31:0]   WIN        = 32'(WIN_SCORE);
    localparam logic [11:0]   NET        = 12'(NET_X);

    typedef enum logic [2:0] {
        S_IDLE, S_READY, S_SERVE, S_PLAY, S_POINT, S_CHECK, S_END
    } state_t;

    state_t        state, next_state;
    logic [PW-1:0] pre_cnt;
    logic [15:0]   tick_cnt;
    logic          tick, timed, pausable;
    logic          score_evt, win_set, win_val;

    assign tick     = (pre_cnt == PRE_LAST);
    assign timed    = (state == S_READY) || (state == S_SERVE) || (state == S_POINT);
    assign pausable = timed || (state == S_PLAY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // run_en low wins over every other transition, including a same-cycle floor touch
    always_comb begin
        next_state = state;
        score_evt  = 1'b0;
        win_set    = 1'b0;
        win_val    = 1'b0;
        if (!run_en) begin
            next_state = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  next_state = S_READY;
                S_READY: if (!pause && tick && tick_cnt == READY_LAST) next_state = S_SERVE;
                S_SERVE: if (!pause && tick && tick_cnt == SERVE_LAST) next_state = S_PLAY;
                S_PLAY: begin
                    if (!pause && floor_hit) begin
                        next_state = S_POINT;
                        score_evt  = 1'b1;
                    end
                end
                S_POINT: if (!pause && tick && tick_cnt == POINT_LAST) next_state = S_CHECK;
                S_CHECK: begin
                    if (32'(player_score) >= WIN) begin
                        win_set    = 1'b1;
                        next_state = S_END;
                    end else if (32'(computer_score) >= WIN) begin
                        win_set    = 1'b1;
                        win_val    = 1'b1;
                        next_state = S_END;
                    end else begin
                        next_state = S_SERVE;
                    end
                end
                S_END:   next_state = S_END;
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
        end else if (next_state != state) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
        end else if (timed && !pause) begin
            if (tick) begin
                pre_cnt  <= '0;
                tick_cnt <= tick_cnt + 16'd1;
            end else begin
                pre_cnt <= pre_cnt + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            player_score   <= 4'd0;
            computer_score <= 4'd0;
            who_win        <= 1'b0;
            winner         <= 1'b0;
        end else if (next_state == S_IDLE) begin
            player_score   <= 4'd0;
            computer_score <= 4'd0;
            who_win        <= 1'b0;
            winner         <= 1'b0;
        end else begin
            if (score_evt) begin
                if (ball_x >= NET) begin
                    if (computer_score != 4'hF) computer_score <= computer_score + 4'd1;
                    who_win <= 1'b1;
                end else begin
                    if (player_score != 4'hF) player_score <= player_score + 4'd1;
                    who_win <= 1'b0;
                end
            end
            if (win_set) winner <= win_val;
        end
    end

    always_comb begin
        game_state = 2'd0;
        unique case (state)
            S_IDLE, S_READY:  game_state = 2'd0;
            S_SERVE, S_POINT: game_state = 2'd1;
            S_PLAY, S_CHECK:  game_state = 2'd2;
            S_END:            game_state = 2'd3;
            default:          game_state = 2'd0;
        endcase
    end

    assign point_pulse = score_evt;
    assign freeze      = run_en && pause && pausable;

endmodule

// File: tb/tb_rally_sequencer.sv
// Directed bench for rally_sequencer: vector table for the opening rallies, then hand-written corner sequences.
module tb_rally_sequencer;
    logic        clk, reset_n, run_en, pause, floor_hit;
    logic [11:0] ball_x;
    logic [1:0]  game_state, game_state2;
    logic        who_win, winner, point_pulse, freeze;
    logic        who_win2, winner2, point_pulse2, freeze2;
    logic [3:0]  player_score, computer_score, player_score2, computer_score2;

    int compared   = 0;
    int mismatched = 0;
    int pulse_cnt  = 0;
    int p0, n;

    rally_sequencer #(.TICK_DIV(4), .READY_TICKS(3), .SERVE_TICKS(2), .POINT_TICKS(2),
                      .WIN_SCORE(3), .NET_X(160)) dut (
        .clk(clk), .reset_n(reset_n), .run_en(run_en), .pause(pause),
        .floor_hit(floor_hit), .ball_x(ball_x), .game_state(game_state),
        .who_win(who_win), .winner(winner), .player_score(player_score),
        .computer_score(computer_score), .point_pulse(point_pulse), .freeze(freeze));

    rally_sequencer #(.TICK_DIV(4), .READY_TICKS(3), .SERVE_TICKS(2), .POINT_TICKS(2),
                      .WIN_SCORE(20), .NET_X(160)) dut_sat (
        .clk(clk), .reset_n(reset_n), .run_en(run_en), .pause(pause),
        .floor_hit(floor_hit), .ball_x(ball_x), .game_state(game_state2),
        .who_win(who_win2), .winner(winner2), .player_score(player_score2),
        .computer_score(computer_score2), .point_pulse(point_pulse2), .freeze(freeze2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (point_pulse) pulse_cnt <= pulse_cnt + 1;

    typedef struct {
        logic        run_en;
        logic        pause;
        logic        floor_hit;
        logic [11:0] ball_x;
        int          cyc;
        logic [1:0]  gs;
        logic [3:0]  ps;
        logic [3:0]  cs;
        logic        who;
        logic        pulse;
        logic        frz;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic p, input logic f, input logic [11:0] x,
                                input int c, input logic [1:0] g, input logic [3:0] ps,
                                input logic [3:0] cs, input logic w, input logic pl, input logic fz);
        vec_t v;
        v.run_en = r; v.pause = p; v.floor_hit = f; v.ball_x = x; v.cyc = c;
        v.gs = g; v.ps = ps; v.cs = cs; v.who = w; v.pulse = pl; v.frz = fz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] gs_of(input logic sel);
        return sel ? game_state2 : game_state;
    endfunction

    task automatic wait_gs(input logic [1:0] target, input logic sel, input string name);
        for (int k = 0; k < 100 && gs_of(sel) != target; k++) step(1);
        chk(name, 32'(gs_of(sel)), 32'(target));
    endtask

    // Runs from READY/SERVE into PLAY, scores one touch at x, returns one cycle after CHECK
    task automatic play_point(input logic [11:0] x, input logic sel);
        wait_gs(2'd2, sel, "reach_play");
        floor_hit = 1'b1;
        ball_x    = x;
        step(1);
        floor_hit = 1'b0;
        wait_gs(2'd2, sel, "reach_check");
        step(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; run_en = 1'b0; pause = 1'b0; floor_hit = 1'b0; ball_x = 12'd0;
        #2;
        chk("rst_state",  32'(game_state), 0);
        chk("rst_pscore", 32'(player_score), 0);
        chk("rst_cscore", 32'(computer_score), 0);
        chk("rst_who",    32'(who_win), 0);
        chk("rst_winner", 32'(winner), 0);
        chk("rst_pulse",  32'(point_pulse), 0);
        chk("rst_freeze", 32'(freeze), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // run pause floor x cyc | state ps cs who pulse freeze
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 12'd0,   2,  2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'd0,   1,  2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'd0,   11, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'd0,   1,  2'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'd0,   7,  2'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'd0,   1,  2'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 12'd200, 0,  2'd2, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 12'd200, 1,  2'd1, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'd0,   7,  2'd1, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'd0,   1,  2'd2, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'd0,   1,  2'd1, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'd0,   7,  2'd1, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'd0,   1,  2'd2, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 12'd159, 0,  2'd2, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 12'd159, 1,  2'd1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'd0,   7,  2'd1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'd0,   1,  2'd2, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'd0,   1,  2'd1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 12'd0,   8,  2'd2, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            run_en = vecs[i].run_en; pause = vecs[i].pause;
            floor_hit = vecs[i].floor_hit; ball_x = vecs[i].ball_x;
            step(vecs[i].cyc);
            chk($sformatf("vec%0d_state", i),  32'(game_state),     32'(vecs[i].gs));
            chk($sformatf("vec%0d_pscore", i), 32'(player_score),   32'(vecs[i].ps));
            chk($sformatf("vec%0d_cscore", i), 32'(computer_score), 32'(vecs[i].cs));
            chk($sformatf("vec%0d_who", i),    32'(who_win),        32'(vecs[i].who));
            chk($sformatf("vec%0d_pulse", i),  32'(point_pulse),    32'(vecs[i].pulse));
            chk($sformatf("vec%0d_freeze", i), 32'(freeze),         32'(vecs[i].frz));
        end

        // Net boundary, and a touch held through POINT/CHECK/SERVE scores once
        floor_hit = 1'b1; ball_x = 12'd160;
        p0 = pulse_cnt;
        #1;
        chk("net_pulse", 32'(point_pulse), 1);
        step(1);
        chk("net_cscore", 32'(computer_score), 2);
        chk("net_who",    32'(who_win), 1);
        step(16);
        chk("hold_state",  32'(game_state), 1);
        chk("hold_cscore", 32'(computer_score), 2);
        chk("hold_pscore", 32'(player_score), 1);
        chk("hold_pulses", 32'(pulse_cnt - p0), 1);
        floor_hit = 1'b0;
        step(1);
        chk("hold_play", 32'(game_state), 2);

        // Pause 20 cycles mid-SERVE stretches it from 8 to 28 cycles
        floor_hit = 1'b1; ball_x = 12'd10;
        step(1);
        floor_hit = 1'b0;
        chk("p2_pscore", 32'(player_score), 2);
        wait_gs(2'd2, 1'b0, "p2_check");
        step(1);
        chk("serve_entry", 32'(game_state), 1);
        n = 1;
        repeat (3) begin
            step(1);
            if (game_state == 2'd1) n++;
        end
        pause = 1'b1;
        #1;
        chk("serve_freeze", 32'(freeze), 1);
        repeat (20) begin
            step(1);
            if (game_state == 2'd1) n++;
        end
        chk("serve_freeze_held", 32'(freeze), 1);
        pause = 1'b0;
        for (int k = 0; k < 40 && game_state == 2'd1; k++) begin
            step(1);
            if (game_state == 2'd1) n++;
        end
        chk("serve_dwell", 32'(n), 28);
        chk("serve_exit_play", 32'(game_state), 2);
        chk("unfreeze", 32'(freeze), 0);

        // Floor touch while paused in PLAY is ignored
        pause = 1'b1; floor_hit = 1'b1; ball_x = 12'd10;
        p0 = pulse_cnt;
        #1;
        chk("pplay_pulse",  32'(point_pulse), 0);
        chk("pplay_freeze", 32'(freeze), 1);
        step(5);
        chk("pplay_state",  32'(game_state), 2);
        chk("pplay_pscore", 32'(player_score), 2);
        chk("pplay_pulses", 32'(pulse_cnt - p0), 0);
        pause = 1'b0; floor_hit = 1'b0;
        step(1);
        chk("pplay_resume", 32'(game_state), 2);

        // Abandon match, then a player win
        run_en = 1'b0;
        step(1);
        chk("abort_state",  32'(game_state), 0);
        chk("abort_cscore", 32'(computer_score), 0);
        chk("abort_pscore", 32'(player_score), 0);
        run_en = 1'b1;
        p0 = pulse_cnt;
        repeat (3) play_point(12'd10, 1'b0);
        chk("pwin_state",  32'(game_state), 3);
        chk("pwin_winner", 32'(winner), 0);
        chk("pwin_pscore", 32'(player_score), 3);
        chk("pwin_cscore", 32'(computer_score), 0);
        chk("pwin_pulses", 32'(pulse_cnt - p0), 3);
        pause = 1'b1;
        #1;
        chk("end_nofreeze", 32'(freeze), 0);
        pause = 1'b0;

        // Second instance never ends; keep scoring until it saturates
        repeat (14) play_point(12'd10, 1'b1);
        chk("sat_pscore", 32'(player_score2), 15);
        chk("sat_cscore", 32'(computer_score2), 0);
        chk("sat_state",  32'(game_state2), 1);
        chk("sat_winner", 32'(winner2), 0);
        chk("sat_who",    32'(who_win2), 0);
        chk("sat_pulse",  32'(point_pulse2), 0);
        chk("sat_freeze", 32'(freeze2), 0);
        chk("end_hold_state",  32'(game_state), 3);
        chk("end_hold_pscore", 32'(player_score), 3);
        run_en = 1'b0;
        step(1);
        chk("end_idle_state",  32'(game_state), 0);
        chk("end_idle_pscore", 32'(player_score), 0);
        chk("sat_clear",       32'(player_score2), 0);

        // npc wins a match
        run_en = 1'b1;
        repeat (3) play_point(12'd200, 1'b0);
        chk("cwin_state",  32'(game_state), 3);
        chk("cwin_winner", 32'(winner), 1);
        chk("cwin_cscore", 32'(computer_score), 3);
        chk("cwin_who",    32'(who_win), 1);
        chk("cwin_pscore", 32'(player_score), 0);
        run_en = 1'b0;
        step(1);
        chk("cwin_idle_winner", 32'(winner), 0);
        chk("cwin_idle_cscore", 32'(computer_score), 0);

        // Async reset between edges mid-PLAY
        run_en = 1'b1;
        play_point(12'd200, 1'b0);
        wait_gs(2'd2, 1'b0, "pre_reset_play");
        chk("pre_reset_cscore", 32'(computer_score), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_state",  32'(game_state), 0);
        chk("arst_cscore", 32'(computer_score), 0);
        chk("arst_who",    32'(who_win), 0);
        chk("arst_pscore", 32'(player_score), 0);
        chk("arst_winner", 32'(winner), 0);
        chk("arst_freeze", 32'(freeze), 0);
        step(1);
        reset_n = 1'b1;

        // run_en drop coincident with a floor touch in PLAY
        wait_gs(2'd2, 1'b0, "post_reset_play");
        run_en = 1'b0; floor_hit = 1'b1; ball_x = 12'd10;
        p0 = pulse_cnt;
        #1;
        chk("drop_pulse", 32'(point_pulse), 0);
        step(1);
        chk("drop_state",  32'(game_state), 0);
        chk("drop_pscore", 32'(player_score), 0);
        chk("drop_cscore", 32'(computer_score), 0);
        chk("drop_pulses", 32'(pulse_cnt - p0), 0);
        floor_hit = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
